// File: rtl/sensors_collector.sv
// Sequential poller for NR_OF_SENSORS temperature sensors sharing one req/valid link.
// Results accumulate in shadow registers and are committed atomically on entry to DONE.
module sensors_collector #(
  parameter int NR_OF_SENSORS  = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  output logic [7:0]                 sensor_sel_o,
  output logic                       sensor_req_o,
  input  logic                       sensor_valid_i,
  input  logic [7:0]                 sensor_data_i,
  output logic [NR_OF_SENSORS*8-1:0] sensors_data_o,
  output logic [NR_OF_SENSORS-1:0]   sensors_en_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam logic [7:0]  LAST_SEL = 8'(NR_OF_SENSORS - 1);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_NEXT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 sel_q, sel_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [NR_OF_SENSORS*8-1:0] sh_data_q, sh_data_d;
  logic [NR_OF_SENSORS-1:0]   sh_en_q, sh_en_d;
  logic [NR_OF_SENSORS*8-1:0] out_data_q, out_data_d;
  logic [NR_OF_SENSORS-1:0]   out_en_q, out_en_d;
  logic                       req_q, req_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       wr_s;
  logic                       wr_en_s;
  logic [7:0]                 wr_data_s;

  // Next-state, shadow-capture and snapshot-commit logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    sh_data_d  = sh_data_q;
    sh_en_d    = sh_en_q;
    out_data_d = out_data_q;
    out_en_d   = out_en_q;
    wr_s       = 1'b0;
    wr_en_s    = 1'b0;
    wr_data_s  = 8'd0;

    case (state_q)
      ST_IDLE: begin
        sel_d = 8'd0;
        if (start_i) begin
          state_d = ST_WAIT;
          cnt_d   = 16'd0;
          sh_en_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A response on the final timeout cycle still counts as an answer.
        if (sensor_valid_i) begin
          wr_s      = 1'b1;
          wr_en_s   = 1'b1;
          wr_data_s = sensor_data_i;
          state_d   = ST_NEXT;
        end else if (cnt_q == CNT_LAST) begin
          wr_s      = 1'b1;
          wr_en_s   = 1'b0;
          wr_data_s = 8'd0;
          state_d   = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_NEXT: begin
        cnt_d = 16'd0;
        if (sel_q == LAST_SEL) begin
          state_d    = ST_DONE;
          out_data_d = sh_data_q;
          out_en_d   = sh_en_q;
        end else begin
          sel_d   = sel_q + 8'd1;
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sel_d   = 8'd0;
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = 8'd0;
        cnt_d   = 16'd0;
      end
    endcase

    for (int k = 0; k < NR_OF_SENSORS; k++) begin
      sh_en_d[k]        = (wr_s && (sel_q == 8'(k))) ? wr_en_s   : sh_en_d[k];
      sh_data_d[k*8 +: 8] = (wr_s && (sel_q == 8'(k))) ? wr_data_s : sh_data_d[k*8 +: 8];
    end

    req_d  = (state_d == ST_WAIT);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, shadow and output registers; reset aborts any scan in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= 8'd0;
      cnt_q      <= 16'd0;
      sh_data_q  <= '0;
      sh_en_q    <= '0;
      out_data_q <= '0;
      out_en_q   <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      sh_data_q  <= sh_data_d;
      sh_en_q    <= sh_en_d;
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sensor_sel_o   = sel_q;
  assign sensor_req_o   = req_q;
  assign sensors_data_o = out_data_q;
  assign sensors_en_o   = out_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_sensors_collector.sv
// Scoreboard bench for sensors_collector: directed scans, expected snapshots queued at start.
module tb_sensors_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sensor_sel;
  logic        sensor_req;
  logic        sensor_valid = 1'b0;
  logic [7:0]  sensor_data = 8'd0;
  logic [39:0] sensors_data;
  logic [4:0]  sensors_en;
  logic        busy;
  logic        done;

  sensors_collector #(.NR_OF_SENSORS(5), .TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .sensor_sel_o(sensor_sel), .sensor_req_o(sensor_req),
    .sensor_valid_i(sensor_valid), .sensor_data_i(sensor_data),
    .sensors_data_o(sensors_data), .sensors_en_o(sensors_en),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [39:0] data;
    logic [4:0]  en;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hold_errs = 0;
  int          sel_glitch = 0;
  logic [39:0] last_data = 40'd0;
  logic [4:0]  last_en = 5'd0;
  int          cfg_delay[0:7];
  logic [7:0]  cfg_data[0:7];
  int          dwell[0:7];
  bit          rand_mode = 1'b0;
  bit          noise = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Sensor model: answers after cfg_delay WAIT cycles (0 = never); records dwell per sensor.
  initial begin
    int w = 0;
    int cur = 0;
    forever begin
      @(negedge clk);
      if (rand_mode) begin
        sensor_valid = 1'($urandom_range(0, 1));
        sensor_data  = 8'($urandom);
      end else if (sensor_req) begin
        if (w > 0 && int'(sensor_sel) != cur) sel_glitch++;
        cur = int'(sensor_sel) & 7;
        w++;
        sensor_valid = (cfg_delay[cur] == w);
        sensor_data  = (cfg_delay[cur] == w) ? cfg_data[cur] : 8'hA5;
      end else begin
        if (w > 0) dwell[cur] = w;
        w = 0;
        sensor_valid = noise;
        sensor_data  = 8'hEE;
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse and checks snapshot holds between pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_data = 40'd0;
      last_en   = 5'd0;
      if (sensors_data !== 40'd0 || sensors_en !== 5'd0) hold_errs++;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("snap_data", 64'(sensors_data), 64'(e.data));
        chk("snap_en", 64'(sensors_en), 64'(e.en));
        chk("busy_in_done", 64'(busy), 64'd1);
        last_data = e.data;
        last_en   = e.en;
      end
    end else begin
      if (sensors_data !== last_data || sensors_en !== last_en) hold_errs++;
    end
  end

  task automatic set_cfg(input int d0, input int d1, input int d2, input int d3, input int d4,
                         input logic [7:0] base);
    cfg_delay[0] = d0; cfg_delay[1] = d1; cfg_delay[2] = d2;
    cfg_delay[3] = d3; cfg_delay[4] = d4;
    for (int k = 0; k < 5; k++) cfg_data[k] = base + 8'(k);
  endtask

  // Starts a scan; lat is the hand-computed done cycle count (cycle 1 follows the sampling edge).
  task automatic start_scan(input bit push, input int lat, input logic [39:0] d, input logic [4:0] en);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 64'd1, 64'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_start", 64'(busy), 64'd1);
    if (push) begin
      e.cyc  = cyc + lat - 1;
      e.data = d;
      e.en   = en;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      cfg_delay[k] = 1;
      cfg_data[k]  = 8'd0;
      dwell[k]     = 0;
    end

    // Reset held with random inputs
    rand_mode = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    #1;
    chk("rst_req", 64'(sensor_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sel", 64'(sensor_sel), 64'd0);
    chk("rst_data", 64'(sensors_data), 64'd0);
    chk("rst_en", 64'(sensors_en), 64'd0);
    @(negedge clk);
    rand_mode = 1'b0;
    start = 1'b0;
    sensor_valid = 1'b0;
    #2 rst_n = 1'b1;

    // All sensors immediate: 2*5+1 = 11
    set_cfg(1, 1, 1, 1, 1, 8'd20);
    start_scan(1'b1, 11, 40'h1817161514, 5'b11111);
    wait_done();

    // Sensor 2 silent: 2+2+16+2+2+1 = 25
    set_cfg(1, 1, 0, 1, 1, 8'd20);
    start_scan(1'b1, 25, 40'h1817001514, 5'b11011);
    wait_done();
    @(negedge clk);
    chk("dwell_s2_timeout", 64'(dwell[2]), 64'd15);
    chk("dwell_s1_fast", 64'(dwell[1]), 64'd1);

    // Sensor 1 answers on its 15th cycle, noise in gaps, start pulsed mid-scan and in DONE
    set_cfg(1, 15, 1, 1, 1, 8'd30);
    noise = 1'b1;
    start_scan(1'b1, 25, 40'h2221201F1E, 5'b11111);
    repeat (5) @(negedge clk);
    start = 1'b1;
    wait_done();
    @(negedge clk);
    start = 1'b0;
    noise = 1'b0;
    chk("dwell_s1_last", 64'(dwell[1]), 64'd15);
    repeat (3) begin
      @(negedge clk);
      chk("no_rescan_busy", 64'(busy), 64'd0);
    end

    // Reset mid-scan at sel=3, then a normal scan: 3+2+4+2+2+1 = 14
    set_cfg(1, 1, 1, 1, 1, 8'd60);
    start_scan(1'b0, 0, 40'd0, 5'd0);
    begin
      int n = 0;
      while (sensor_sel != 8'd3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("reach_sel3", 64'(sensor_sel), 64'd3);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", 64'(sensor_req), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sel", 64'(sensor_sel), 64'd0);
    chk("abort_data", 64'(sensors_data), 64'd0);
    chk("abort_en", 64'(sensors_en), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    set_cfg(2, 1, 3, 1, 1, 8'h40);
    start_scan(1'b1, 14, 40'h4443424140, 5'b11111);
    wait_done();

    // Back-to-back scans; second has sensor 4 timing out: 4*2+16+1 = 25
    set_cfg(1, 1, 1, 1, 1, 8'd20);
    start_scan(1'b1, 11, 40'h1817161514, 5'b11111);
    wait_done();
    set_cfg(1, 1, 1, 1, 0, 8'h50);
    start_scan(1'b1, 25, 40'h0053525150, 5'b01111);
    wait_done();
    repeat (3) @(negedge clk);

    chk("snapshot_hold", 64'(hold_errs), 64'd0);
    chk("sel_stable", 64'(sel_glitch), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
